// File: rtl/pulse_stretcher_if.sv
// rtl/pulse_stretcher_if.sv - event strobe in, stretched level and queue status out
interface pulse_stretcher_if #(
  parameter int PW = 2
);
  logic          pulse_in;
  logic          clr_ovf;
  logic          level_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (
    output pulse_in,
    output clr_ovf,
    input  level_out,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  pulse_in,
    input  clr_ovf,
    output level_out,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches 1-cycle events into HIGH windows separated by LOW gaps
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_PEND    = 3
) (
  input  logic              clk,
  input  logic              rst,
  pulse_stretcher_if.slave  bus
);

  localparam int PW   = $clog2(MAX_PEND + 1);
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_RELOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX    = PW'(MAX_PEND);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [PW-1:0] pend_q, pend_nxt;
  logic          ovf_q, ovf_nxt;
  logic          level_q, level_nxt;
  logic          busy_q, busy_nxt;

  logic          gap_final;
  logic          ovf_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      pend_q  <= pend_nxt;
      ovf_q   <= ovf_nxt;
      level_q <= level_nxt;
      busy_q  <= busy_nxt;
    end
  end

  // Last gap cycle hands straight over to the next window when work is waiting.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    pend_nxt  = pend_q;
    ovf_set   = 1'b0;
    gap_final = (state_q == S_GAP) && (cnt_q == '0);

    case (state_q)
      S_IDLE: begin
        if (bus.pulse_in) begin
          state_nxt = S_HIGH;
          cnt_nxt   = HOLD_RELOAD;
        end
      end
      S_HIGH: begin
        if (cnt_q != '0) begin
          cnt_nxt = cnt_q - CW'(1);
        end else begin
          state_nxt = S_GAP;
          cnt_nxt   = GAP_RELOAD;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_nxt = cnt_q - CW'(1);
        end else if ((pend_q != '0) || bus.pulse_in) begin
          state_nxt = S_HIGH;
          cnt_nxt   = HOLD_RELOAD;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if ((state_q != S_IDLE) && !gap_final && bus.pulse_in) begin
      if (pend_q < PEND_MAX) begin
        pend_nxt = pend_q + PW'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end

    // A pulse landing on the handover cycle replaces the queued event being consumed.
    if (gap_final && (pend_q != '0) && !bus.pulse_in) begin
      pend_nxt = pend_q - PW'(1);
    end

    if (ovf_set) begin
      ovf_nxt = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_nxt = 1'b0;
    end else begin
      ovf_nxt = ovf_q;
    end
  end

  always_comb begin
    level_nxt = (state_nxt == S_HIGH);
    busy_nxt  = (state_nxt != S_IDLE);
  end

  assign bus.level_out = level_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pend_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - vector table, corner sequences and random run against a reference model
module tb_pulse_stretcher;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int MAXP = 3;
  localparam int PW   = $clog2(MAXP + 1);

  logic clk = 1'b0;
  logic rst;

  pulse_stretcher_if #(.PW(PW)) bus ();

  pulse_stretcher #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .MAX_PEND    (MAXP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r;
    logic p;
    logic c;
    int   lvl;
    int   bsy;
    int   pnd;
    int   ovf;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: busy cycles remaining in the current window+gap, plus queued events.
  int m_left = 0;
  int m_pend = 0;
  int m_ovf  = 0;

  task automatic add(input logic r, input logic p, input logic c,
                     input int l, input int b, input int pe, input int o, input int n);
    vec_t e;
    e.r = r; e.p = p; e.c = c; e.lvl = l; e.bsy = b; e.pnd = pe; e.ovf = o;
    for (int k = 0; k < n; k++) tbl.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic p, input logic c);
    bit set;
    set = 1'b0;
    if (r) begin
      m_left = 0; m_pend = 0; m_ovf = 0;
      return;
    end
    if (m_left == 0) begin
      if (p) m_left = HOLD + GAP;
    end else if (m_left == 1) begin
      if (m_pend > 0 || p) begin
        m_left = HOLD + GAP;
        if (m_pend > 0 && !p) m_pend--;
      end else begin
        m_left = 0;
      end
    end else begin
      m_left--;
      if (p) begin
        if (m_pend < MAXP) m_pend++;
        else set = 1'b1;
      end
    end
    if (set) m_ovf = 1;
    else if (c) m_ovf = 0;
  endtask

  task automatic step(input logic r, input logic p, input logic c);
    rst = r;
    bus.pulse_in = p;
    bus.clr_ovf = c;
    @(posedge clk);
    model_step(r, p, c);
    #1;
  endtask

  int rises;
  int highs;
  logic prev;

  initial begin
    rst = 1'b1;
    bus.pulse_in = 1'b0;
    bus.clr_ovf = 1'b0;
    #1;

    // single event, reset state first
    add(1, 0, 0, 0, 0, 0, 0, 3);
    add(0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 2);
    // three back-to-back events
    add(0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 1, 0, 1, 1, 1, 0, 1);
    add(0, 1, 0, 1, 1, 2, 0, 1);
    add(0, 0, 0, 1, 1, 2, 0, 1);
    add(0, 0, 0, 0, 1, 2, 0, 2);
    add(0, 0, 0, 1, 1, 1, 0, 4);
    add(0, 0, 0, 0, 1, 1, 0, 2);
    add(0, 0, 0, 1, 1, 0, 0, 4);
    add(0, 0, 0, 0, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // pulse exactly on the last gap cycle with nothing queued
    add(0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 2);
    add(0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].p, tbl[i].c);
      chk($sformatf("vec%0d.level", i), int'(bus.level_out), tbl[i].lvl);
      chk($sformatf("vec%0d.busy", i), int'(bus.busy), tbl[i].bsy);
      chk($sformatf("vec%0d.pending", i), int'(bus.pending), tbl[i].pnd);
      chk($sformatf("vec%0d.overflow", i), int'(bus.overflow), tbl[i].ovf);
    end

    // saturation: five events in the first window
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0);
      if (bus.level_out && !prev) rises++;
      prev = bus.level_out;
      if (i == 3) chk("sat.pending", int'(bus.pending), 3);
    end
    chk("sat.overflow", int'(bus.overflow), 1);
    chk("sat.pending_held", int'(bus.pending), 3);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0);
      if (bus.level_out && !prev) rises++;
      prev = bus.level_out;
    end
    chk("sat.windows", rises, 4);
    chk("sat.idle_busy", int'(bus.busy), 0);
    chk("sat.idle_pending", int'(bus.pending), 0);
    chk("sat.ovf_sticky", int'(bus.overflow), 1);

    // clear racing a dropped event, then clear alone
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    chk("clr.pending_full", int'(bus.pending), 3);
    step(0, 1, 1);
    chk("clr.set_wins", int'(bus.overflow), 1);
    step(0, 0, 1);
    chk("clr.alone", int'(bus.overflow), 0);

    // reset mid-window discards queued events
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    chk("rst.pending_before", int'(bus.pending), 2);
    chk("rst.level_before", int'(bus.level_out), 1);
    step(1, 0, 0);
    chk("rst.level", int'(bus.level_out), 0);
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.pending", int'(bus.pending), 0);
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0);
      if (bus.level_out || bus.busy) highs++;
    end
    chk("rst.no_windows", highs, 0);

    // random traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 35),
           ($urandom_range(0, 99) < 5));
      chk($sformatf("rnd%0d.level", i), int'(bus.level_out), (m_left > GAP) ? 1 : 0);
      chk($sformatf("rnd%0d.busy", i), int'(bus.busy), (m_left > 0) ? 1 : 0);
      chk($sformatf("rnd%0d.pending", i), int'(bus.pending), m_pend);
      chk($sformatf("rnd%0d.overflow", i), int'(bus.overflow), m_ovf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
